// File: rtl/div_iter_unit.sv
// Radix-2 restoring divider for DIV/DIVU, producing {HI=rem, LO=quot}.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations.
module div_iter_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sign,
  input  logic               annul,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               stall_div,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  logic               accept;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic               last;

  always_comb begin
    accept = (state_q == S_IDLE) & start & ~annul;
    abs_a  = (sign & a[WIDTH-1]) ? -a : a;
    abs_b  = (sign & b[WIDTH-1]) ? -b : b;
    // Quotient MSB shifts into the partial remainder each step.
    rem_sh = {rem_q, quot_q[WIDTH-1]};
    ge     = rem_sh >= {1'b0, dvsr_q};
    diff   = rem_sh[WIDTH-1:0] - dvsr_q;
    rem_nx = ge ? diff : rem_sh[WIDTH-1:0];
    rem_fix  = negr_q ? -rem_q : rem_q;
    quot_fix = negq_q ? -quot_q : quot_q;
    last   = cnt_q == CNT_W'(WIDTH - 1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    res_d   = res_q;
    stall_div = 1'b0;
    ready     = 1'b0;
    result    = res_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          stall_div = 1'b1;
          negq_d = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
          negr_d = sign & a[WIDTH-1];
          dvsr_d = abs_b;
          quot_d = abs_a;
          rem_d  = '0;
          cnt_d  = '0;
          state_d = S_BUSY;
`ifdef DIV_ZERO_FAST_EN
          if (b == '0) begin
            rem_d   = abs_a;
            quot_d  = '1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_BUSY: begin
        stall_div = ~annul;
        rem_d  = rem_nx;
        quot_d = {quot_q[WIDTH-2:0], ge};
        cnt_d  = cnt_q + 1'b1;
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        if (!annul) begin
          ready  = 1'b1;
          res_d  = {rem_fix, quot_fix};
          result = res_d;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (annul) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvsr_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvsr_q  <= dvsr_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed bench for div_iter_unit: latency, signs, zero divisor,
// overflow, back-to-back, annul and reset.
module tb_div_iter_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sign;
  logic        annul;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall_div;
  logic        ready;
  logic [63:0] result;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  div_iter_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .sign(sign),
    .annul(annul),
    .a(a),
    .b(b),
    .stall_div(stall_div),
    .ready(ready),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic launch(input logic s, input logic [31:0] x,
                        input logic [31:0] y);
    start = 1'b1;
    sign  = s;
    a     = x;
    b     = y;
  endtask

  // Called at posedge+1 in the accept cycle; returns in the ready cycle.
  task automatic wait_ready(output int lat, output int stalls,
                            output logic stall_rdy);
    int cyc;
    cyc = 0;
    stalls = 0;
    lat = -1;
    stall_rdy = 1'bx;
    forever begin
      #3;
      if (ready) begin
        lat = cyc;
        stall_rdy = stall_div;
        break;
      end
      if (stall_div) stalls++;
      if (cyc >= 100) break;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sign = 1'b0; annul = 1'b0;
    a = '0; b = '0;
    repeat (3) @(posedge clk);
    #4;
    n_cmp++;
    if (stall_div !== 1'b0) begin
      n_bad++; $display("FAIL reset_stall got %b want 0", stall_div);
    end
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_ready got %b want 0", ready);
    end
    n_cmp++;
    if (result !== 64'd0) begin
      n_bad++; $display("FAIL reset_result got %h want 0", result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_divu_basic();
    int lat, st; logic sr;
    @(posedge clk); #1;
    launch(1'b0, 32'd100, 32'd7);
    wait_ready(lat, st, sr);
    n_cmp++;
    if (lat !== 33) begin
      n_bad++; $display("FAIL divu_latency got %0d want 33", lat);
    end
    n_cmp++;
    if (st !== 33) begin
      n_bad++; $display("FAIL divu_stall_cycles got %0d want 33", st);
    end
    n_cmp++;
    if (sr !== 1'b0) begin
      n_bad++; $display("FAIL divu_stall_at_ready got %b want 0", sr);
    end
    n_cmp++;
    if (result !== {32'd2, 32'd14}) begin
      n_bad++; $display("FAIL divu_result got %h want %h", result,
                        {32'd2, 32'd14});
    end
    start = 1'b0;
  endtask

  task automatic test_signed();
    int lat, st; logic sr;
    @(posedge clk); #1;
    launch(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_ready(lat, st, sr);
    n_cmp++;
    if (lat !== 33) begin
      n_bad++; $display("FAIL div_neg_latency got %0d want 33", lat);
    end
    n_cmp++;
    if (result !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      n_bad++; $display("FAIL div_neg_a got %h want ffffffff_fffffffd",
                        result);
    end
    start = 1'b0;
    @(posedge clk); #1;
    launch(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_ready(lat, st, sr);
    n_cmp++;
    if (result !== {32'd1, 32'hFFFF_FFFD}) begin
      n_bad++; $display("FAIL div_neg_b got %h want 00000001_fffffffd",
                        result);
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat, st; logic sr;
    @(posedge clk); #1;
    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_ready(lat, st, sr);
    n_cmp++;
    if (result !== {32'd0, 32'h8000_0000}) begin
      n_bad++; $display("FAIL overflow got %h want 00000000_80000000",
                        result);
    end
    // start stays high through DONE; it must not retrigger there.
    launch(1'b0, 32'd9, 32'd3);
    @(posedge clk); #1;
    wait_ready(lat, st, sr);
    n_cmp++;
    if (lat !== 33) begin
      n_bad++; $display("FAIL b2b_latency got %0d want 33", lat);
    end
    n_cmp++;
    if (result !== {32'd0, 32'd3}) begin
      n_bad++; $display("FAIL b2b_result got %h want 00000000_00000003",
                        result);
    end
    start = 1'b0;
  endtask

  task automatic test_div_zero();
    int lat, st; logic sr;
    @(posedge clk); #1;
    launch(1'b0, 32'd5, 32'd0);
    wait_ready(lat, st, sr);
    n_cmp++;
    if (lat !== ZLAT) begin
      n_bad++; $display("FAIL divz_latency got %0d want %0d", lat, ZLAT);
    end
    n_cmp++;
    if (st !== ZLAT) begin
      n_bad++; $display("FAIL divz_stall_cycles got %0d want %0d", st, ZLAT);
    end
    n_cmp++;
    if (result !== {32'd5, 32'hFFFF_FFFF}) begin
      n_bad++; $display("FAIL divz_unsigned got %h want 00000005_ffffffff",
                        result);
    end
    start = 1'b0;
    @(posedge clk); #1;
    launch(1'b1, 32'hFFFF_FFF8, 32'd0);
    wait_ready(lat, st, sr);
    n_cmp++;
    if (result !== {32'hFFFF_FFF8, 32'd1}) begin
      n_bad++; $display("FAIL divz_signed_neg got %h want fffffff8_00000001",
                        result);
    end
    start = 1'b0;
    @(posedge clk); #1;
    launch(1'b1, 32'd5, 32'd0);
    wait_ready(lat, st, sr);
    n_cmp++;
    if (result !== {32'd5, 32'hFFFF_FFFF}) begin
      n_bad++; $display("FAIL divz_signed_pos got %h want 00000005_ffffffff",
                        result);
    end
    start = 1'b0;
  endtask

  task automatic test_annul();
    int pulses;
    @(posedge clk); #1;
    launch(1'b0, 32'd50, 32'd5);
    repeat (10) begin
      @(posedge clk); #1;
    end
    annul = 1'b1;
    #3;
    n_cmp++;
    if (stall_div !== 1'b0) begin
      n_bad++; $display("FAIL annul_stall got %b want 0", stall_div);
    end
    @(posedge clk); #1;
    annul = 1'b0;
    start = 1'b0;
    #3;
    n_cmp++;
    if (stall_div !== 1'b0 || ready !== 1'b0) begin
      n_bad++; $display("FAIL annul_idle got stall=%b ready=%b want 0 0",
                        stall_div, ready);
    end
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #4;
      if (ready) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++; $display("FAIL annul_no_ready got %0d pulses want 0", pulses);
    end
    n_cmp++;
    if (result !== {32'd5, 32'hFFFF_FFFF}) begin
      n_bad++; $display("FAIL annul_result got %h want 00000005_ffffffff",
                        result);
    end
  endtask

  task automatic test_rst_mid();
    int lat, st; logic sr;
    @(posedge clk); #1;
    launch(1'b0, 32'd100, 32'd7);
    repeat (20) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk); #4;
    n_cmp++;
    if (stall_div !== 1'b0 || ready !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_ctrl got stall=%b ready=%b want 0 0",
                        stall_div, ready);
    end
    n_cmp++;
    if (result !== 64'd0) begin
      n_bad++; $display("FAIL rst_mid_result got %h want 0", result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    launch(1'b0, 32'd8, 32'd2);
    wait_ready(lat, st, sr);
    n_cmp++;
    if (lat !== 33) begin
      n_bad++; $display("FAIL rst_fresh_latency got %0d want 33", lat);
    end
    n_cmp++;
    if (result !== {32'd0, 32'd4}) begin
      n_bad++; $display("FAIL rst_fresh_result got %h want 00000000_00000004",
                        result);
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_back_to_back();
    test_div_zero();
    test_annul();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
